// File: rtl/gerenciador_leituras_rr.sv
// Round-robin read arbiter: many expander requesters share one multi-port memory read interface.
// Each accepted request gets a one-hot grant pulse and a matching one-hot ready pulse MEM_LATENCY cycles later.
module gerenciador_leituras_rr #(
    parameter int NUM_READ_PORTS   = 8,
    parameter int NUM_SOLICITACOES = 8,
    parameter int DATA_WIDH        = 32,
    parameter int ADDR_WIDTH       = 8,
    parameter int MEM_LATENCY      = 1
) (
    input  logic                                             clk,
    input  logic                                             rst_n,
    input  logic [NUM_SOLICITACOES-1:0]                      lvv_read_en_in,
    input  logic [ADDR_WIDTH*NUM_READ_PORTS*NUM_SOLICITACOES-1:0] lvv_read_addr_in,
    output logic [NUM_SOLICITACOES-1:0]                      grant_out,
    output logic                                             mem_read_en_out,
    output logic [ADDR_WIDTH*NUM_READ_PORTS-1:0]             read_addr_out,
    input  logic [DATA_WIDH*NUM_READ_PORTS-1:0]              mem_read_data_in,
    output logic [NUM_SOLICITACOES-1:0]                      ready_out,
    output logic [DATA_WIDH*NUM_READ_PORTS-1:0]              read_data_out
);

    localparam int N        = NUM_SOLICITACOES;
    localparam int PTR_W    = (N > 1) ? $clog2(N) : 1;
    localparam int BUNDLE_W = ADDR_WIDTH * NUM_READ_PORTS;

    logic [PTR_W-1:0]    ptr_q;
    logic [PTR_W-1:0]    ptr_next;
    logic [PTR_W-1:0]    winner;
    logic [PTR_W:0]      scan_idx;
    logic                found;
    logic [N-1:0]        eligible;
    logic [N-1:0]        grant_d;
    logic [N-1:0]        grant_q;
    logic                mem_en_q;
    logic [BUNDLE_W-1:0] addr_sel;
    logic [BUNDLE_W-1:0] addr_q;
    logic [N-1:0]        ret_pipe [MEM_LATENCY];

    // Requesters granted this cycle are masked so a still-high request is not issued twice.
    always_comb begin
        eligible = lvv_read_en_in & ~grant_q;
        winner   = '0;
        found    = 1'b0;
        scan_idx = '0;
        for (int i = 0; i < N; i++) begin
            scan_idx = {1'b0, ptr_q} + (PTR_W+1)'(i);
            if (scan_idx >= (PTR_W+1)'(N))
                scan_idx = scan_idx - (PTR_W+1)'(N);
            if (!found && eligible[scan_idx[PTR_W-1:0]]) begin
                winner = scan_idx[PTR_W-1:0];
                found  = 1'b1;
            end
        end

        grant_d = '0;
        if (found)
            grant_d[winner] = 1'b1;

        if (winner == PTR_W'(N-1))
            ptr_next = '0;
        else
            ptr_next = winner + PTR_W'(1);

        addr_sel = '0;
        for (int k = 0; k < N; k++) begin
            if (winner == PTR_W'(k))
                addr_sel = lvv_read_addr_in[k*BUNDLE_W +: BUNDLE_W];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant_q  <= '0;
            mem_en_q <= 1'b0;
            addr_q   <= '0;
            ptr_q    <= '0;
        end else begin
            grant_q  <= grant_d;
            mem_en_q <= found;
            if (found) begin
                addr_q <= addr_sel;
                ptr_q  <= ptr_next;
            end
        end
    end

    // Return path: the issued grant travels alongside the memory access so ready lines up with its data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < MEM_LATENCY; i++)
                ret_pipe[i] <= '0;
        end else begin
            ret_pipe[0] <= grant_q;
            for (int i = 1; i < MEM_LATENCY; i++)
                ret_pipe[i] <= ret_pipe[i-1];
        end
    end

    assign grant_out       = grant_q;
    assign mem_read_en_out = mem_en_q;
    assign read_addr_out   = addr_q;
    assign ready_out       = ret_pipe[MEM_LATENCY-1];
    assign read_data_out   = mem_read_data_in;

endmodule

// File: tb/tb_gerenciador_leituras_rr.sv
// Self-checking bench for gerenciador_leituras_rr: directed grant checks plus a scoreboard for tagged read returns.
module tb_gerenciador_leituras_rr;

    localparam int N  = 4;
    localparam int P  = 2;
    localparam int AW = 8;
    localparam int D  = 32;
    localparam int L  = 2;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [N-1:0]      lvv_read_en_in = '0;
    logic [AW*P*N-1:0] lvv_read_addr_in;
    logic [N-1:0]      grant_out;
    logic              mem_read_en_out;
    logic [AW*P-1:0]   read_addr_out;
    logic [D*P-1:0]    mem_read_data_in;
    logic [N-1:0]      ready_out;
    logic [D*P-1:0]    read_data_out;

    logic [AW*P-1:0]   req_addr [N];
    logic [AW*P-1:0]   held_addr = '0;

    int check_count = 0;
    int err_count   = 0;
    int cyc         = 0;

    typedef struct {
        logic [N-1:0]   tag;
        logic [D*P-1:0] data;
        int             due;
    } sb_t;
    sb_t sb_q [$];

    gerenciador_leituras_rr #(
        .NUM_READ_PORTS  (P),
        .NUM_SOLICITACOES(N),
        .DATA_WIDH       (D),
        .ADDR_WIDTH      (AW),
        .MEM_LATENCY     (L)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .lvv_read_en_in  (lvv_read_en_in),
        .lvv_read_addr_in(lvv_read_addr_in),
        .grant_out       (grant_out),
        .mem_read_en_out (mem_read_en_out),
        .read_addr_out   (read_addr_out),
        .mem_read_data_in(mem_read_data_in),
        .ready_out       (ready_out),
        .read_data_out   (read_data_out)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always_comb begin
        for (int k = 0; k < N; k++)
            lvv_read_addr_in[k*AW*P +: AW*P] = req_addr[k];
    end

    // Memory model: data is a fixed function of the address bundle, valid L cycles after the strobe.
    function automatic logic [D*P-1:0] mem_f(input logic [AW*P-1:0] a);
        logic [D*P-1:0] r;
        logic [7:0]     ab;
        r = '0;
        for (int p = 0; p < P; p++) begin
            ab = a[p*AW +: AW];
            r[p*D +: D] = {8'hA0 + 8'(p), 8'h5A, ab, ~ab};
        end
        return r;
    endfunction

    logic            v1 = 1'b0, v2 = 1'b0;
    logic [AW*P-1:0] a1 = '0, a2 = '0;
    logic [D*P-1:0]  rnd = '0;

    always @(posedge clk) begin
        v1  <= mem_read_en_out;
        a1  <= read_addr_out;
        v2  <= v1;
        a2  <= a1;
        rnd <= {$urandom(), $urandom()};
    end

    always_comb mem_read_data_in = v2 ? mem_f(a2) : rnd;

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        check_count++;
        if (actual !== expected) begin
            err_count++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Return monitor: a ready pulse must appear exactly on the due cycle of the oldest outstanding read.
    always @(negedge clk) begin
        sb_t e;
        if (sb_q.size() != 0 && sb_q[0].due == cyc) begin
            e = sb_q.pop_front();
            checkOutput("ready_tag", 64'(ready_out), 64'(e.tag));
            checkOutput("ready_data", 64'(read_data_out), 64'(e.data));
        end else if (ready_out !== '0) begin
            checkOutput("ready_unexpected", 64'(ready_out), 64'd0);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [N-1:0] en);
        lvv_read_en_in = en;
        tick();
    endtask

    task automatic expectIssue(input string tag, input logic [N-1:0] exp_grant);
        sb_t e;
        checkOutput({tag, "_grant"}, 64'(grant_out), 64'(exp_grant));
        checkOutput({tag, "_en"}, 64'(mem_read_en_out), 64'(exp_grant != '0));
        for (int k = 0; k < N; k++) begin
            if (exp_grant[k]) begin
                held_addr = req_addr[k];
                e.tag  = exp_grant;
                e.data = mem_f(req_addr[k]);
                e.due  = cyc + L;
                sb_q.push_back(e);
            end
        end
        checkOutput({tag, "_addr"}, 64'(read_addr_out), 64'(held_addr));
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_grant"}, 64'(grant_out), 64'd0);
        checkOutput({tag, "_en"}, 64'(mem_read_en_out), 64'd0);
        checkOutput({tag, "_addr"}, 64'(read_addr_out), 64'd0);
        checkOutput({tag, "_ready"}, 64'(ready_out), 64'd0);
    endtask

    task automatic doReset(input string tag);
        lvv_read_en_in = '0;
        rst_n = 1'b0;
        #1;
        checkResetOutputs(tag);
        sb_q.delete();
        held_addr = '0;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic idle(input int n);
        lvv_read_en_in = '0;
        repeat (n) tick();
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        req_addr[0] = 16'hA53C;
        req_addr[1] = 16'h1177;
        req_addr[2] = 16'h22C8;
        req_addr[3] = 16'h3399;

        doReset("rst0");
        tick();

        // Single request, then idle with address held
        applyStimulus(4'b0001);
        expectIssue("s1", 4'b0001);
        applyStimulus(4'b0000);
        expectIssue("s1_idle", 4'b0000);
        idle(4);

        // All requesting from reset, each dropped on its grant
        doReset("rst1");
        applyStimulus(4'b1111);
        expectIssue("s2_g0", 4'b0001);
        applyStimulus(4'b1110);
        expectIssue("s2_g1", 4'b0010);
        applyStimulus(4'b1100);
        expectIssue("s2_g2", 4'b0100);
        applyStimulus(4'b1000);
        expectIssue("s2_g3", 4'b1000);
        applyStimulus(4'b0000);
        expectIssue("s2_end", 4'b0000);

        // Pointer wrap after requester 3, and scan wrap from pointer 3
        applyStimulus(4'b0101);
        expectIssue("s3_g0", 4'b0001);
        applyStimulus(4'b0100);
        expectIssue("s3_g2", 4'b0100);
        applyStimulus(4'b0011);
        expectIssue("s3_wrap", 4'b0001);
        applyStimulus(4'b0010);
        expectIssue("s3_g1", 4'b0010);
        applyStimulus(4'b0000);
        expectIssue("s3_end", 4'b0000);

        // Lone requester held: alternate-cycle grants, new address presented on each grant
        req_addr[0] = 16'h4E01;
        for (int i = 0; i < 6; i++) begin
            applyStimulus(4'b0001);
            expectIssue("s4", (i % 2 == 0) ? 4'b0001 : 4'b0000);
            if (i % 2 == 0)
                req_addr[0] = req_addr[0] + 16'h0101;
        end
        applyStimulus(4'b0000);
        expectIssue("s4_end", 4'b0000);
        idle(4);

        // Reset right after a grant: read dropped, pointer back to 0
        applyStimulus(4'b0010);
        expectIssue("s5_pre", 4'b0010);
        doReset("s5_rst");
        for (int i = 0; i < 4; i++) begin
            applyStimulus(4'b0000);
            expectIssue("s5_quiet", 4'b0000);
        end
        applyStimulus(4'b1111);
        expectIssue("s5_ptr0", 4'b0001);
        applyStimulus(4'b0000);
        expectIssue("s5_end", 4'b0000);

        // Withdrawn request: only requester 1 gets through
        applyStimulus(4'b0110);
        expectIssue("s6_g1", 4'b0010);
        applyStimulus(4'b0000);
        expectIssue("s6_none_a", 4'b0000);
        applyStimulus(4'b0000);
        expectIssue("s6_none_b", 4'b0000);
        idle(4);

        checkOutput("sb_empty", 64'(sb_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", check_count, err_count);
        $finish;
    end

endmodule

// File: doc/gerenciador_leituras_rr.md
Name: gerenciador_leituras_rr

Overview:
- Round-robin read arbiter between NUM_SOLICITACOES requesters (approved-list expanders) and one NUM_READ_PORTS-wide memory read interface.
- Successor to the single-cycle read manager. Adds fair rotating priority, an explicit per-request grant, and a configurable memory latency.
- Adds a requester-tagged read-valid return path, so every requester knows exactly which data beat is its own.
- Sits between the expanders and the visited-list memory banks.

Parameters:
- NUM_READ_PORTS, 8, number of parallel memory read ports (addresses per request).
- NUM_SOLICITACOES, 8, number of requesters (N); must be at least 1.
- DATA_WIDH, 32, data width per read port.
- ADDR_WIDTH, 8, address width per read port.
- MEM_LATENCY, 1, cycles from read_addr_out/mem_read_en_out to valid mem_read_data_in; must be at least 1.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- lvv_read_en_in  in  NUM_SOLICITACOES  per-requester read request; held high until granted.
- lvv_read_addr_in  in  ADDR_WIDTH*NUM_READ_PORTS*NUM_SOLICITACOES  requester k's address bundle occupies slice [k*AW*P +: AW*P].
- grant_out  out  NUM_SOLICITACOES  one-hot, 1-cycle pulse: request accepted, addresses captured.
- mem_read_en_out  out  1  memory read strobe.
- read_addr_out  out  ADDR_WIDTH*NUM_READ_PORTS  addresses to memory.
- mem_read_data_in  in  DATA_WIDH*NUM_READ_PORTS  memory read data.
- ready_out  out  NUM_SOLICITACOES  one-hot read-valid, aligned with read_data_out.
- read_data_out  out  DATA_WIDH*NUM_READ_PORTS  equal to mem_read_data_in (combinational passthrough).

Behaviour:
- Reset (async, rst_n=0):
  - grant_out, mem_read_en_out, read_addr_out, ready_out all 0.
  - Latency pipeline cleared.
  - Priority pointer = 0 (requester 0 has highest priority).
- Arbitration (each cycle t):
  - Eligible set = lvv_read_en_in & ~grant_out. A requester granted in the current cycle is masked, so a still-high request is not double-issued.
  - Winner = first eligible index scanning ptr, ptr+1, ..., N-1, 0, ..., ptr-1.
- Issue (registered, visible at cycle t+1):
  - grant_out = one-hot(winner).
  - mem_read_en_out = 1.
  - read_addr_out = winner's address slice.
  - ptr = (winner+1) mod N; wraps from N-1 to 0.
- No eligible requester:
  - grant_out = 0, mem_read_en_out = 0.
  - read_addr_out and ptr hold their values.
- Requester protocol:
  - Address must be stable while request is high and ungranted.
  - Requester may drop its request, or present a new address with request held, in the cycle grant_out[k]=1.
  - The new request is eligible from the following cycle.
- Throughput and fairness:
  - One issue per cycle when any requester is eligible.
  - A single continuously-requesting requester with no competition is granted every other cycle.
  - A held request is granted within N cycles.
- Return path:
  - Shift pipeline of depth MEM_LATENCY carries the one-hot grant.
  - ready_out = grant issued exactly MEM_LATENCY cycles earlier (a cycle with no issue yields 0).
  - read_data_out = mem_read_data_in.
- Simultaneous events:
  - A new request arriving in the same cycle as a return is independent; both proceed.
  - Request deasserted before grant: it is withdrawn, no grant is given.
- Reset mid-operation: in-flight reads are dropped; ready_out is never asserted for them after reset release.
- N=1: pointer is a constant 0; behaviour is otherwise identical.

Test Plan:
All scenarios use N=4, P=2, AW=8, D=32, MEM_LATENCY=2.

1. Single request:
   - Stimulus: lvv_read_en_in=0001 at t0, addr slice0=16'hA5_3C.
   - Response: t1: grant_out=0001, mem_read_en_out=1, read_addr_out=16'hA53C. t3: ready_out=0001, read_data_out=mem_read_data_in.
2. All requesting, held:
   - Stimulus: lvv_read_en_in=1111 from reset, each dropped on its grant.
   - Response: grants 0001,0010,0100,1000 on consecutive cycles; ready_out follows with the same order 2 cycles later.
3. Pointer wrap:
   - Stimulus: after granting requester 3, lvv_read_en_in=0101.
   - Response: grant requester 0, then 2.
4. Single requester held high for 6 cycles with no competition.
   - Response: grant_out=0001 on alternate cycles, 3 grants total; no two consecutive grants.
5. Reset mid-flight:
   - Stimulus: rst_n low 1 cycle after a grant.
   - Response: all outputs 0 immediately; no ready_out pulse for the dropped read; ptr=0 after release.
6. Withdrawn request:
   - Stimulus: lvv_read_en_in=0110 for 1 cycle, then 0000.
   - Response: only requester 1 is granted; requester 2 is never granted.
